reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//   Parametrised 2-read/1-write register file; successor to the fixed 16x8 file.
//   Generalises DATA_W/ADDR_W and adds registered reads with valid flags and write-first bypass.
//   Adds a sequenced bulk-clear engine with busy/done handshake. Sits beside the datapath ALU as the operand store.
// PARAMETERS
//   DATA_W  8  entry width in bits (>=1)
//   ADDR_W  4  address width; DEPTH = 2**ADDR_W entries (ADDR_W 1..8)
// PORTS
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous, active-low reset
//   wr_en      in   1       write strobe
//   wr_addr    in   ADDR_W  write address
//   wr_data    in   DATA_W  write data
//   wr_rej     out  1       1-cycle pulse: write dropped (clear in progress)
//   rd_en1     in   1       port-1 read strobe
//   rd_addr1   in   ADDR_W  port-1 address
//   rd_data1   out  DATA_W  port-1 registered data
//   rd_valid1  out  1       port-1 data valid (1 cycle after rd_en1)
//   rd_en2     in   1       port-2 read strobe
//   rd_addr2   in   ADDR_W  port-2 address
//   rd_data2   out  DATA_W  port-2 registered data
//   rd_valid2  out  1       port-2 data valid
//   clr_req    in   1       start bulk clear (sampled in IDLE only)
//   clr_busy   out  1       high while clear engine is walking entries
//   clr_done   out  1       1-cycle pulse after last entry cleared
// BEHAVIOUR
//   Reset (reset_n=0, async): all entries 0; FSM=IDLE; clear counter 0; every output 0.
//   Write: wr_en=1 in IDLE/DONE -> entry[wr_addr] <= wr_data at that edge.
//   Read: rd_enN=1 at edge t -> rd_dataN, rd_validN=1 after edge t (1-cycle latency);
//     rd_enN=0 -> rd_validN=0, rd_dataN holds last value.
//   Bypass: same-cycle wr_en and rd_enN with wr_addr==rd_addrN (write accepted) -> rd_dataN = wr_data.
//   Both read ports independent; same address on both ports legal, identical data.
//   FSM states: IDLE, CLEAR, DONE.
//     IDLE -> CLEAR when clr_req=1; counter <= 0; clr_busy=1 from next cycle.
//     CLEAR: entry[counter] <= 0 each cycle, counter++; after entry DEPTH-1 -> DONE.
//       Clear takes exactly DEPTH cycles with clr_busy=1.
//     DONE: clr_done=1, clr_busy=0 for one cycle -> IDLE unconditionally.
//   clr_req in CLEAR or DONE: ignored (no restart, no queueing).
//   wr_en in CLEAR: write dropped, wr_rej=1 next cycle; wr_rej=0 otherwise.
//   Reads in CLEAR: accepted, rd_valid asserts normally, rd_data = 0.
//   Counter wraps from DEPTH-1 to 0 at the CLEAR->DONE transition; no overflow beyond ADDR_W bits.
//   reset_n low mid-clear: immediate abort, all entries 0, FSM IDLE, no clr_done pulse.
//   No width conversion: wr_data stored verbatim, DATA_W bits.
// CONFIGURATION
//   RF_ZERO_REG_EN defined: entry 0 hardwired to 0; writes to addr 0 silently ignored
//     (no wr_rej); reads of addr 0 return 0 including the bypass case.
//   RF_ZERO_REG_EN undefined: entry 0 is an ordinary storage entry.
// TESTING
//   1. Reset, read addr 0..15 on both ports -> all rd_data 0, rd_valid high 1 cycle after each rd_en.
//   2. Write 0xA5 to addr 3, next cycle read port1 addr 3 -> rd_data1=0xA5, rd_valid1=1 one cycle later.
//   3. Same cycle wr 0x3C @7 and rd_en2 @7 -> rd_data2=0x3C next cycle (bypass); port1 @6 unaffected.
//   4. Fill all 16 entries, pulse clr_req -> clr_busy high 16 cycles, clr_done 1 pulse, all reads 0;
//      wr_en 0x11 @2 during busy -> wr_rej pulse, addr 2 still 0 after clear.
//   5. Drive reset_n low at clear cycle 5 -> clr_busy 0 immediately, no clr_done, all entries 0.
//   6. RF_ZERO_REG_EN defined: write 0xFF @0 then read @0 -> 0x00, wr_rej stays 0; undefined -> 0xFF.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file: registered reads with write-first bypass and a bulk-clear engine.
// Optional RF_ZERO_REG_EN: entry 0 reads as zero and ignores writes.
module reg_file_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rej,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] cnt_r, cnt_next_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_acc_s;
  logic [DATA_W-1:0] rd_next1_s, rd_next2_s;

  // Read value as seen at this edge: zero while clearing, new write data on address match.
  function automatic logic [DATA_W-1:0] rd_pick(
    input logic              clearing,
    input logic              wr_acc,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    if (clearing) begin
      v = ZERO_DAT;
    end else if (wr_acc && (wa == ra)) begin
      v = wd;
    end else begin
      v = stored;
    end
`ifdef RF_ZERO_REG_EN
    if (ra == ZERO_IDX) begin
      v = ZERO_DAT;
    end else begin
      v = v;
    end
`endif
    return v;
  endfunction

  // Write acceptance: blocked during clear (and for entry 0 when it is hardwired).
  always_comb begin
    wr_acc_s = wr_en && (state_r != ST_CLEAR);
`ifdef RF_ZERO_REG_EN
    if (wr_addr == ZERO_IDX) begin
      wr_acc_s = 1'b0;
    end else begin
      wr_acc_s = wr_acc_s;
    end
`endif
  end

  // Next read data for both ports.
  always_comb begin
    rd_next1_s = rd_pick(state_r == ST_CLEAR, wr_acc_s, wr_addr, wr_data, rd_addr1, mem_r[rd_addr1]);
    rd_next2_s = rd_pick(state_r == ST_CLEAR, wr_acc_s, wr_addr, wr_data, rd_addr2, mem_r[rd_addr2]);
  end

  // Clear FSM next-state and counter.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_next_s = ST_CLEAR;
          cnt_next_s   = ZERO_IDX;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_next_s = cnt_r + ADDR_W'(1);
        if (cnt_r == LAST_IDX) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM state, counter and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= ZERO_IDX;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_rej   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      clr_busy <= (state_next_s == ST_CLEAR);
      clr_done <= (state_next_s == ST_DONE);
      wr_rej   <= wr_en && (state_r == ST_CLEAR);
    end
  end

  // Storage array: clear engine owns the write port while walking entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ZERO_DAT;
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[cnt_r] <= ZERO_DAT;
    end else if (wr_acc_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read ports; data holds when not enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data1  <= ZERO_DAT;
      rd_valid1 <= 1'b0;
      rd_data2  <= ZERO_DAT;
      rd_valid2 <= 1'b0;
    end else begin
      rd_valid1 <= rd_en1;
      rd_valid2 <= rd_en2;
      if (rd_en1) begin
        rd_data1 <= rd_next1_s;
      end
      if (rd_en2) begin
        rd_data2 <= rd_next2_s;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (DATA_W=8, ADDR_W=4): vector table plus clear/reset sequences.
module tb_reg_file_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_rej;
  logic       rd_en1;
  logic [3:0] rd_addr1;
  logic [7:0] rd_data1;
  logic       rd_valid1;
  logic       rd_en2;
  logic [3:0] rd_addr2;
  logic [7:0] rd_data2;
  logic       rd_valid2;
  logic       clr_req;
  logic       clr_busy;
  logic       clr_done;

  int checks = 0;
  int errors = 0;

`ifdef RF_ZERO_REG_EN
  localparam logic [7:0] Z0 = 8'h00;
`else
  localparam logic [7:0] Z0 = 8'hFF;
`endif

  reg_file_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rej(wr_rej),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_valid1(rd_valid1),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_valid2(rd_valid2),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       r1;
    logic [3:0] a1;
    logic       r2;
    logic [3:0] a2;
    logic       ev1;
    logic [7:0] ed1;
    logic       ev2;
    logic [7:0] ed2;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    rd_en1 = 1'b0; rd_addr1 = 4'd0; rd_en2 = 1'b0; rd_addr2 = 4'd0;
    clr_req = 1'b0;
  endtask

  // Drive at negedge, then sample 1 time unit after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    idle_inputs();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
  endtask

  task automatic read_both(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    idle_inputs();
    rd_en1 = 1'b1; rd_addr1 = a; rd_en2 = 1'b1; rd_addr2 = a;
    cycle();
    chk({name, "_v1"}, 32'(rd_valid1), 32'd1);
    chk({name, "_d1"}, 32'(rd_data1), 32'(exp));
    chk({name, "_v2"}, 32'(rd_valid2), 32'd1);
    chk({name, "_d2"}, 32'(rd_data2), 32'(exp));
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    vt[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[1] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 8'hA5, 1'b0, 8'h00};
    vt[2] = '{1'b1, 4'd7, 8'h3C, 1'b1, 4'd6, 1'b1, 4'd7, 1'b1, 8'h00, 1'b1, 8'h3C};
    vt[3] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h3C};
    vt[4] = '{1'b1, 4'd6, 8'h5A, 1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 8'h3C, 1'b1, 8'h3C};
    vt[5] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1'b1, 4'd3, 1'b1, 8'h5A, 1'b1, 8'hA5};
    vt[6] = '{1'b1, 4'd0, 8'hFF, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, Z0,    1'b0, 8'hA5};
    vt[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, Z0,    1'b1, Z0};

    idle_inputs();
    reset_n = 1'b0;
    #12;
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_rej", 32'(wr_rej), 32'd0);
    chk("rst_v1", 32'(rd_valid1), 32'd0);
    chk("rst_d2", 32'(rd_data2), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Post-reset contents, both ports.
    for (int a = 0; a < 16; a++) read_both(4'(a), 8'h00, "rst_rd");

    // Vector table: write, read, bypass, hold, zero-register behaviour.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_en1 = vt[i].r1; rd_addr1 = vt[i].a1; rd_en2 = vt[i].r2; rd_addr2 = vt[i].a2;
      clr_req = 1'b0;
      cycle();
      chk($sformatf("vec%0d_v1", i), 32'(rd_valid1), 32'(vt[i].ev1));
      chk($sformatf("vec%0d_d1", i), 32'(rd_data1), 32'(vt[i].ed1));
      chk($sformatf("vec%0d_v2", i), 32'(rd_valid2), 32'(vt[i].ev2));
      chk($sformatf("vec%0d_d2", i), 32'(rd_data2), 32'(vt[i].ed2));
      chk($sformatf("vec%0d_rej", i), 32'(wr_rej), 32'd0);
    end

    // Bulk clear of a full array, with a rejected write and ignored clr_req mid-clear.
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'(8'h10 + a));
    @(negedge clk);
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    chk("clr_start_busy", 32'(clr_busy), 32'd1);
    busy_cnt = 1;
    done_cnt = 0;
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 3) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
        rd_en1 = 1'b1; rd_addr1 = 4'd15;
      end
      if (k == 5 || k == 17) clr_req = 1'b1;
      if (k == 17) begin
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h77;
      end
      cycle();
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 3) begin
        chk("clr_rej", 32'(wr_rej), 32'd1);
        chk("clr_rd_v1", 32'(rd_valid1), 32'd1);
        chk("clr_rd_d1", 32'(rd_data1), 32'd0);
      end
      if (k == 4) chk("clr_rej_pulse", 32'(wr_rej), 32'd0);
      if (k == 17) chk("done_wr_rej", 32'(wr_rej), 32'd0);
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("clr_done_count", 32'(done_cnt), 32'd1);
    chk("clr_done_cycle", 32'(done_at), 32'd16);
    for (int a = 0; a < 16; a++) read_both(4'(a), (a == 9) ? 8'h77 : 8'h00, "post_clr");

    // Reset asserted mid-clear aborts the engine with no done pulse.
    do_write(4'd14, 8'hE1);
    do_write(4'd15, 8'hF2);
    @(negedge clk);
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idle_inputs();
      cycle();
    end
    chk("abort_pre_busy", 32'(clr_busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(clr_busy), 32'd0);
    chk("abort_done", 32'(clr_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (clr_done) done_cnt++;
      if (clr_busy) busy_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_no_busy", 32'(busy_cnt), 32'd0);
    read_both(4'd14, 8'h00, "abort_rd14");
    read_both(4'd15, 8'h00, "abort_rd15");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
